program_sequencer: RTL and testbench

//  Fetch/decode/execute sequencer for the 6-bit uProcessor core. Owns the PC, fetches from

---
 rtl/program_sequencer.sv | 77 +++++++
 tb/tb_program_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// program_sequencer: fetch/decode/execute sequencer with PC, imem handshake, CE gating, HALT, step mode and retired counter
module program_sequencer #(
  parameter int PC_W     = 8,
  parameter int PROG_LEN = 256,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step_mode,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [5:0]       imem_data,
  output logic [5:0]       ins,
  input  logic             dec_reg_ce,
  input  logic             dec_a_ce,
  input  logic             dec_cy_ce,
  output logic             reg_ce,
  output logic             a_ce,
  output logic             cy_ce,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
  state_t           r_state, w_next;
  logic [PC_W-1:0]  r_pc;
  logic [5:0]       r_ins;
  logic [CNT_W-1:0] r_retired;
  logic [PC_W-1:0]  w_pc_inc;
  logic             w_is_halt;
  logic             w_exec;
  assign w_pc_inc  = (r_pc == PC_W'(PROG_LEN - 1)) ? '0 : r_pc + 1'b1;
  assign w_is_halt = r_ins[5:2] == 4'd6;
  assign w_exec    = r_state == S_EXEC;
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  // next-state: run only matters in IDLE/HALT, ack only in FETCH
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = run ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: w_next = w_is_halt ? S_HALT : S_EXEC;
      S_EXEC:   w_next = step_mode ? S_IDLE : S_FETCH;
      S_HALT:   w_next = run ? S_FETCH : S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end
  // pc advances on EXEC and on the DECODE->HALT transition; counter saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= '0;
      r_ins     <= '0;
      r_retired <= '0;
    end else begin
      if (r_state == S_FETCH && imem_ack) r_ins <= imem_data;
      if (w_exec || (r_state == S_DECODE && w_is_halt)) r_pc <= w_pc_inc;
      if (w_exec && !(&r_retired)) r_retired <= r_retired + 1'b1;
    end
  end
  assign imem_req  = r_state == S_FETCH;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign ins       = r_ins;
  assign retired   = r_retired;
  assign halted    = r_state == S_HALT;
  assign busy      = r_state == S_FETCH || r_state == S_DECODE || w_exec;
  assign reg_ce    = dec_reg_ce & w_exec;
  assign a_ce      = dec_a_ce & w_exec;
  assign cy_ce     = dec_cy_ce & w_exec;
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: randomized transaction-level checks of program_sequencer against a pc/retired model
module tb_program_sequencer;
  localparam int PC_W = 3, PROG_LEN = 4, CNT_W = 2;
  localparam int RET_MAX = 2 ** CNT_W - 1;
  logic clk = 0, rst = 1, run = 0, step_mode = 0, imem_ack = 0;
  logic [5:0] imem_data = '0;
  logic dec_reg_ce = 1, dec_a_ce = 1, dec_cy_ce = 1;
  logic imem_req, reg_ce, a_ce, cy_ce, halted, busy;
  logic [PC_W-1:0] imem_addr, pc;
  logic [5:0] ins;
  logic [CNT_W-1:0] retired;
  logic [5:0] mem [PROG_LEN];
  int n_tests = 0, n_fail = 0;
  logic [PC_W-1:0] m_pc;
  logic [5:0] m_ins;
  int m_ret, m_where;
  wire [19:0] obs = {imem_req, imem_addr, pc, busy, halted, reg_ce, a_ce, cy_ce, ins, retired};

  program_sequencer #(.PC_W(PC_W), .PROG_LEN(PROG_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .step_mode(step_mode),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ins(ins), .dec_reg_ce(dec_reg_ce), .dec_a_ce(dec_a_ce), .dec_cy_ce(dec_cy_ce),
    .reg_ce(reg_ce), .a_ce(a_ce), .cy_ce(cy_ce), .pc(pc), .halted(halted), .busy(busy),
    .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  function automatic logic [19:0] mk(input logic req, input logic [PC_W-1:0] p, input logic b,
                                     input logic h, input logic [2:0] ce, input logic [5:0] i);
    return {req, p, p, b, h, ce, i, CNT_W'(m_ret)};
  endfunction

  function automatic logic [5:0] rand_ins(input bit h);
    logic [5:0] d;
    d = 6'($urandom);
    d[5:2] = h ? 4'd6 : (d[5:2] == 4'd6 ? 4'd7 : d[5:2]);
    return d;
  endfunction

  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] p);
    return PC_W'((int'(p) + 1) % PROG_LEN);
  endfunction

  task automatic do_reset;
    rst = 1; run = 0; imem_ack = 0;
    @(negedge clk);
    rst = 0;
    m_pc = 0; m_ins = 0; m_ret = 0; m_where = 1;
  endtask

  task automatic go;
    if (m_where != 0) begin
      run = 1;
      @(negedge clk);
      run = 0;
    end
    n_tests++;
    if (obs !== mk(1, m_pc, 1, 0, 0, m_ins)) begin
      n_fail++;
      $display("FAIL go: got %h expected %h", obs, mk(1, m_pc, 1, 0, 0, m_ins));
    end
    m_where = 0;
  endtask

  task automatic do_instr(input int w);
    logic [5:0] d;
    logic [2:0] dce;
    d = mem[m_pc];
    dce = 3'($urandom);
    {dec_reg_ce, dec_a_ce, dec_cy_ce} = 3'b111;
    for (int i = 0; i <= w; i++) begin
      n_tests++;
      if (obs !== mk(1, m_pc, 1, 0, 0, m_ins)) begin
        n_fail++;
        $display("FAIL fetch wait %0d: got %h expected %h", i, obs, mk(1, m_pc, 1, 0, 0, m_ins));
      end
      imem_ack = (i == w);
      imem_data = (i == w) ? d : 6'($urandom);
      @(negedge clk);
    end
    m_ins = d;
    n_tests++;
    if (obs !== mk(0, m_pc, 1, 0, 0, d)) begin
      n_fail++;
      $display("FAIL decode: got %h expected %h", obs, mk(0, m_pc, 1, 0, 0, d));
    end
    {dec_reg_ce, dec_a_ce, dec_cy_ce} = dce;
    imem_ack = 1;
    imem_data = 6'($urandom);
    @(negedge clk);
    if (d[5:2] == 4'd6) begin
      m_pc = next_pc(m_pc);
      m_where = 2;
      n_tests++;
      if (obs !== mk(0, m_pc, 0, 1, 0, d)) begin
        n_fail++;
        $display("FAIL halt: got %h expected %h", obs, mk(0, m_pc, 0, 1, 0, d));
      end
    end else begin
      n_tests++;
      if (obs !== mk(0, m_pc, 1, 0, dce, d)) begin
        n_fail++;
        $display("FAIL exec: got %h expected %h", obs, mk(0, m_pc, 1, 0, dce, d));
      end
      {dec_reg_ce, dec_a_ce, dec_cy_ce} = 3'b111;
      @(negedge clk);
      m_pc = next_pc(m_pc);
      if (m_ret < RET_MAX) m_ret++;
      m_where = step_mode ? 1 : 0;
      n_tests++;
      if (obs !== mk(!step_mode, m_pc, !step_mode, 0, 0, d)) begin
        n_fail++;
        $display("FAIL after exec: got %h expected %h", obs, mk(!step_mode, m_pc, !step_mode, 0, 0, d));
      end
    end
    imem_ack = 0;
    {dec_reg_ce, dec_a_ce, dec_cy_ce} = 3'b111;
  endtask

  task automatic test_reset;
    rst = 1; run = 1; imem_ack = 1; imem_data = 6'h2a;
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs !== 20'h0) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", obs, 20'h0);
    end
    do_reset;
    n_tests++;
    if (obs !== 20'h0) begin
      n_fail++;
      $display("FAIL idle after reset: got %h expected %h", obs, 20'h0);
    end
  endtask

  task automatic test_basic;
    mem[0] = 6'b000001; mem[1] = 6'b011000;
    do_reset;
    go;
    do_instr(0);
    do_instr(0);
    repeat (2) @(negedge clk);
    n_tests++;
    if ({halted, pc, retired} !== {1'b1, 3'd2, 2'd1}) begin
      n_fail++;
      $display("FAIL basic halt hold: got %h expected %h", {halted, pc, retired}, {1'b1, 3'd2, 2'd1});
    end
  endtask

  task automatic test_wait;
    for (int i = 0; i < PROG_LEN; i++) mem[i] = rand_ins(0);
    do_reset;
    go;
    do_instr(3);
    do_instr(1);
    do_instr(4);
  endtask

  task automatic test_wrap;
    for (int i = 0; i < PROG_LEN; i++) mem[i] = rand_ins(0);
    do_reset;
    go;
    repeat (6) do_instr(0);
    n_tests++;
    if (pc !== 3'd2) begin
      n_fail++;
      $display("FAIL wrap pc: got %0d expected 2", pc);
    end
  endtask

  task automatic test_step;
    for (int i = 0; i < PROG_LEN; i++) mem[i] = rand_ins(0);
    do_reset;
    step_mode = 1;
    go;
    do_instr(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== mk(0, m_pc, 0, 0, 0, m_ins)) begin
        n_fail++;
        $display("FAIL step idle %0d: got %h expected %h", i, obs, mk(0, m_pc, 0, 0, 0, m_ins));
      end
    end
    go;
    do_instr(1);
    step_mode = 0;
  endtask

  task automatic test_reset_fetch;
    for (int i = 0; i < PROG_LEN; i++) mem[i] = rand_ins(0);
    do_reset;
    go;
    do_instr(0);
    do_instr(0);
    @(negedge clk);
    rst = 1; imem_ack = 1; imem_data = 6'h15;
    @(negedge clk);
    rst = 0; imem_ack = 0;
    m_pc = 0; m_ins = 0; m_ret = 0; m_where = 1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs !== 20'h0) begin
        n_fail++;
        $display("FAIL reset in fetch %0d: got %h expected %h", i, obs, 20'h0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < PROG_LEN; i++) mem[i] = rand_ins(0);
    do_reset;
    go;
    repeat (5) do_instr($urandom_range(0, 2));
    n_tests++;
    if (retired !== 2'd3) begin
      n_fail++;
      $display("FAIL saturate: got %0d expected 3", retired);
    end
    mem[m_pc] = rand_ins(1);
    do_instr(0);
    go;
    do_instr(0);
  endtask

  task automatic test_random;
    do_reset;
    for (int n = 0; n < 60; n++) begin
      mem[m_pc] = rand_ins($urandom_range(0, 4) == 0);
      step_mode = 1'($urandom);
      go;
      do_instr($urandom_range(0, 3));
    end
    step_mode = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wait;
    test_wrap;
    test_step;
    test_reset_fetch;
    test_saturate;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
